uart_tx_arbiter: RTL and testbench

//  Shares the byte-write port of uart_control (w_en/data_in/full) among NUM_REQ clients.

---
 rtl/uart_arb_pkg.sv | 18 +
 rtl/uart_tx_arbiter_if.sv | 30 +++
 rtl/uart_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit-port arbiter.
// UART_ARB_ID_HEADER_EN (optional) adds the HDR state that emits a client-ID byte.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      XFER = 2'd2
   } state_t;

   localparam logic [3:0] HDR_TAG = 4'hA;

   // Index width for n clients; never below one bit.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client-side request bundle plus the uart_control write port seen by the arbiter.
// The HDR byte (UART_ARB_ID_HEADER_EN) travels on the same uart_* signals.
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   import uart_arb_pkg::*;

   localparam int ID_W = id_width(NUM_REQ);

   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0][7:0]  req_data;
   logic [NUM_REQ-1:0]       req_last;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     uart_w_en;
   logic [7:0]               uart_data_in;
   logic                     uart_full;
   logic [ID_W-1:0]          grant_id;
   logic                     busy;

   modport slave (
      input  req_valid, req_data, req_last, uart_full,
      output req_ready, uart_w_en, uart_data_in, grant_id, busy
   );

   modport master (
      output req_valid, req_data, req_last, uart_full,
      input  req_ready, uart_w_en, uart_data_in, grant_id, busy
   );

endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set request strictly after last_ptr_i, wrapping.
// Independent of UART_ARB_ID_HEADER_EN.
module uart_rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [ID_W-1:0]    last_ptr_i,
   output logic [ID_W-1:0]    winner_o,
   output logic               any_o
);

   logic [ID_W-1:0] idx;

   // Scan from the farthest offset down so the nearest requester is written last and wins.
   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      idx      = '0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         idx = ID_W'((int'(last_ptr_i) + off) % NUM_REQ);
         if (req_i[idx]) begin
            winner_o = idx;
            any_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked sharing of the uart_control byte-write port among NUM_REQ clients.
// Define UART_ARB_ID_HEADER_EN to prefix each grant with a {4'hA, grant_id} header byte.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int MAX_BURST = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   uart_tx_arbiter_if.slave    bus
);

   localparam int ID_W = id_width(NUM_REQ);

   state_t          state_q, state_d;
   logic [ID_W-1:0] grant_q, grant_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]      burst_q, burst_d;
   logic [ID_W-1:0] pick_winner;
   logic            pick_any;

   logic [NUM_REQ-1:0] ready;
   logic               w_en;
   logic [7:0]         data;

   uart_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_pick (
      .req_i      (bus.req_valid),
      .last_ptr_i (rr_ptr_q),
      .winner_o   (pick_winner),
      .any_o      (pick_any)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= ID_W'(NUM_REQ - 1);
         burst_q  <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         burst_q  <= burst_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      burst_d  = burst_q;
      ready    = '0;
      w_en     = 1'b0;
      data     = '0;
      case (state_q)
         IDLE: begin
            if (pick_any) begin
               grant_d  = pick_winner;
               rr_ptr_d = pick_winner;
`ifdef UART_ARB_ID_HEADER_EN
               state_d  = HDR;
`else
               state_d  = XFER;
`endif
            end
         end
`ifdef UART_ARB_ID_HEADER_EN
         HDR: begin
            if (!bus.uart_full) begin
               w_en    = 1'b1;
               data    = {HDR_TAG, 4'(grant_q)};
               state_d = XFER;
            end
         end
`endif
         XFER: begin
            ready[grant_q] = !bus.uart_full;
            w_en           = bus.req_valid[grant_q] & !bus.uart_full;
            if (w_en) begin
               data = bus.req_data[grant_q];
               // Release on the client's last byte or once MAX_BURST bytes have gone out.
               if (bus.req_last[grant_q] || burst_q == 8'(MAX_BURST - 1)) begin
                  burst_d = '0;
                  state_d = IDLE;
               end else begin
                  burst_d = burst_q + 8'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready    = ready;
   assign bus.uart_w_en    = w_en;
   assign bus.uart_data_in = data;
   assign bus.grant_id     = grant_q;
   assign bus.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter; expects header bytes when UART_ARB_ID_HEADER_EN is defined.
module tb_uart_tx_arbiter;
   import uart_arb_pkg::*;

   localparam int NUM_REQ   = 4;
   localparam int MAX_BURST = 16;
`ifdef UART_ARB_ID_HEADER_EN
   localparam int HDR_N = 1;
`else
   localparam int HDR_N = 0;
`endif

   typedef struct { logic [7:0] d; logic l; } item_t;
   typedef struct { logic [3:0] id; logic [7:0] d; } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   item_t cq [NUM_REQ][$];
   exp_t  sb [$];
   int    tests = 0;
   int    fails = 0;
   int    n_acc = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input int c, input logic [7:0] d, input logic l);
      item_t it;
      it.d = d;
      it.l = l;
      cq[c].push_back(it);
   endtask

   task automatic exp_grant(input int c);
      exp_t e;
      if (HDR_N != 0) begin
         e.id = 4'(c);
         e.d  = {HDR_TAG, 4'(c)};
         sb.push_back(e);
      end
   endtask

   task automatic exp_byte(input int c, input logic [7:0] d);
      exp_t e;
      e.id = 4'(c);
      e.d  = d;
      sb.push_back(e);
   endtask

   function automatic int pending();
      int p = sb.size();
      for (int i = 0; i < NUM_REQ; i++) p += cq[i].size();
      return p;
   endfunction

   task automatic clear_all();
      sb.delete();
      for (int i = 0; i < NUM_REQ; i++) cq[i].delete();
   endtask

   task automatic wait_drain(input string tag);
      int k = 0;
      while (pending() != 0 && k < 400) begin
         @(negedge clk);
         #2;
         k++;
      end
      chk(tag, 32'(pending()), 32'd0);
   endtask

   task automatic wait_acc(input string tag, input int target);
      int k = 0;
      while (n_acc < target && k < 200) begin
         @(negedge clk);
         #2;
         k++;
      end
      chk(tag, 32'(n_acc), 32'(target));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      bus.uart_full = 1'b0;
      clear_all();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic chk_outputs_zero(input string tag);
      chk({tag, "_w_en"},  32'(bus.uart_w_en), 32'd0);
      chk({tag, "_busy"},  32'(bus.busy), 32'd0);
      chk({tag, "_grant"}, 32'(bus.grant_id), 32'd0);
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
      chk({tag, "_data"},  32'(bus.uart_data_in), 32'd0);
   endtask

   // Client model + output monitor: drive on negedge, observe, retire handshakes before posedge.
   always @(negedge clk) begin
      logic [NUM_REQ-1:0]      v;
      logic [NUM_REQ-1:0]      l;
      logic [NUM_REQ-1:0][7:0] d;
      exp_t e;
      v = '0;
      l = '0;
      d = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (cq[i].size() > 0) begin
            v[i] = 1'b1;
            d[i] = cq[i][0].d;
            l[i] = cq[i][0].l;
         end
      end
      bus.req_valid = v;
      bus.req_data  = d;
      bus.req_last  = l;
      #1;
      if (bus.uart_w_en === 1'b1) begin
         n_acc++;
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_byte: observed %0h expected none", bus.uart_data_in);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("byte_data",  32'(bus.uart_data_in), 32'(e.d));
            chk("byte_grant", 32'(bus.grant_id), 32'(e.id));
            $display("[TB] t=%0t byte %02h from client %0d", $time, bus.uart_data_in, bus.grant_id);
         end
      end else if (rst_n) begin
         chk("data_idle_zero", 32'(bus.uart_data_in), 32'd0);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (v[i] && bus.req_ready[i] === 1'b1) void'(cq[i].pop_front());
      end
   end

   initial begin
      int base;
      bus.uart_full = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.req_last  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Single requester: client 2 sends 55, C3(last)
      @(posedge clk);
      #1;
      base = n_acc;
      send(2, 8'h55, 1'b0);
      send(2, 8'hC3, 1'b1);
      exp_grant(2);
      exp_byte(2, 8'h55);
      exp_byte(2, 8'hC3);
      wait_drain("single_drain");
      chk("single_pulses", 32'(n_acc - base), 32'(2 + HDR_N));
      repeat (2) @(negedge clk);
      #2;
      chk("single_idle_busy", 32'(bus.busy), 32'd0);

      // Client 3, one byte
      send(3, 8'h11, 1'b1);
      exp_grant(3);
      exp_byte(3, 8'h11);
      wait_drain("c3_drain");

      // All four continuously, 1-byte bursts: rotation 0,1,2,3,0,1,2,3
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < NUM_REQ; c++) begin
            send(c, 8'(8'h20 + 16 * c + r), 1'b1);
            exp_grant(c);
            exp_byte(c, 8'(8'h20 + 16 * c + r));
         end
      end
      wait_drain("rotation_drain");

      // uart_full held 5 cycles mid-burst
      base = n_acc;
      for (int i = 0; i < 4; i++) begin
         send(1, 8'(8'hB0 + i), (i == 3));
         if (i == 0) exp_grant(1);
         exp_byte(1, 8'(8'hB0 + i));
      end
      wait_acc("full_reach", base + HDR_N + 2);
      @(posedge clk);
      #1;
      bus.uart_full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #2;
         chk("full_w_en",  32'(bus.uart_w_en), 32'd0);
         chk("full_ready", 32'(bus.req_ready), 32'd0);
         chk("full_grant", 32'(bus.grant_id), 32'd1);
         chk("full_busy",  32'(bus.busy), 32'd1);
      end
      @(posedge clk);
      #1;
      bus.uart_full = 1'b0;
      wait_drain("full_drain");

      // MAX_BURST release: client 1 never sends last, client 2 waiting
      do_reset();
      for (int i = 0; i < 20; i++) send(1, 8'(8'h40 + i), 1'b0);
      send(2, 8'h99, 1'b1);
      exp_grant(1);
      for (int i = 0; i < MAX_BURST; i++) exp_byte(1, 8'(8'h40 + i));
      exp_grant(2);
      exp_byte(2, 8'h99);
      exp_grant(1);
      for (int i = MAX_BURST; i < 20; i++) exp_byte(1, 8'(8'h40 + i));
      wait_drain("burst_drain");
      @(negedge clk);
      #2;
      chk("burst_hold_busy",  32'(bus.busy), 32'd1);
      chk("burst_hold_grant", 32'(bus.grant_id), 32'd1);

      // Async reset at byte 3 of a client-3 burst
      do_reset();
      base = n_acc;
      exp_grant(3);
      for (int i = 0; i < 6; i++) begin
         send(3, 8'(8'hD0 + i), (i == 5));
         exp_byte(3, 8'(8'hD0 + i));
      end
      wait_acc("rst_reach", base + HDR_N + 3);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      clear_all();
      #1;
      chk_outputs_zero("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(3, 8'h77, 1'b1);
      send(0, 8'h66, 1'b1);
      exp_grant(0);
      exp_byte(0, 8'h66);
      exp_grant(3);
      exp_byte(3, 8'h77);
      wait_drain("post_rst_drain");

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
